maxunpool_12_24: RTL and testbench
==================================

Name: maxunpool_12_24

Overview:
- Inverse of the 24x24 -> 12x12 max-pooling stage.
- Takes a 12x12 map of pooled values plus the 2-bit argmax position recorded per 2x2 window, and rebuilds a 24x24 map.
- Each value is placed at its argmax position inside its 2x2 window; the other three positions in the window are zero.
- Used on the backward / reconstruction path. Uses the same start_flag / end_flag handshake and flat MSB-first buses as the pooling stage, and processes one pooled row per cycle.

Parameters:
- DATA_W, 4, bit width of each pooled value and each output pixel.
- ROWS, 12, pooled map height. Output height is 2*ROWS.
- COLS, 12, pooled map width. Output width is 2*COLS.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_flag  input  1  one-cycle request. Samples in and idx.
- in  input  ROWS*COLS*DATA_W (576)  pooled values. Pixel (r,c) is at in[575-(r*12+c)*4 -: 4].
- idx  input  ROWS*COLS*2 (288)  argmax per window. Entry (r,c) is at idx[287-(r*12+c)*2 -: 2]. bit1 = row offset (0 = top); bit0 = column offset (0 = left).
- out  output  4*ROWS*COLS*DATA_W (2304)  unpooled map. Pixel (y,x) is at out[2303-(y*24+x)*4 -: 4].
- end_flag  output  1  one-cycle completion pulse.
- busy  output  1  high while a frame is being processed.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; row counter = 0.
  - out = 0, end_flag = 0, busy = 0.
  - Input latches and working buffer cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On start_flag = 1, latch in and idx into internal registers, set row = 0, go to RUN.
  - busy rises on the same edge.
- RUN (one pooled row r per cycle, r = 0..11):
  - For each c in 0..11, value v = in(r,c) and index k = idx(r,c).
  - Write the four working-buffer pixels (2r+i, 2c+j), i,j in {0,1}.
  - Pixel gets v when {i,j} == k, else 0. Every output pixel is therefore written exactly once per frame; no pre-clear is needed.
  - At r == 11, go to DONE; otherwise r <= r+1.
- DONE:
  - Copy the working buffer to out.
  - end_flag = 1 for exactly one cycle.
  - busy = 0, return to IDLE.
- Latency:
  - start_flag sampled at edge 0; rows processed at edges 1..12.
  - out and end_flag update at edge 13, so end_flag is high during cycle 13 only.
- Output hold:
  - out is stable from end_flag until the next DONE; the working buffer is separate from out.
  - end_flag is 0 in every cycle other than the DONE cycle.
- start_flag while busy = 1 (RUN or DONE) is ignored and does not restart or corrupt the current frame.
- start_flag in the cycle after DONE (state IDLE) is accepted normally: back-to-back frames are 14 cycles apart.
- Reset mid-RUN: aborts immediately with reset values. No end_flag for the aborted frame; out reads 0.
- Changes on in or idx after the start_flag edge have no effect on the current frame.
- All data is unsigned pass-through; no arithmetic and no saturation.

Test Plan:
1. All in = 4'hF, idx = 2'b00 -> end_flag 13 cycles after start, width one cycle. out(y,x) = F where y and x are both even, else 0.
2. in(r,c) = (r+c) mod 16, idx(r,c) = (r*12+c) mod 4 -> every output pixel matches a software reference model; each 2x2 window has exactly one value at position {i,j} = idx.
3. Frame A completes, then start_flag pulses during frame B with different data at cycle 5 of frame B -> frame B output unaffected, only one end_flag. out holds frame A's data until frame B's end_flag.
4. reset asserted at cycle 6 of RUN -> out = 0, busy = 0, no end_flag. A new start two cycles later completes normally in 13 cycles.
5. Back-to-back: start at edge 0 and again at edge 14 with different data -> end_flag at edges 13 and 27. Second out is correct, with no residue from the first frame.
6. idx = 2'b11, in(0,0) = 4'h9, all others 0 -> out(1,1) = 9; every other pixel is 0, including out(0,0), out(0,1) and out(1,0).

Source files
------------

// File: rtl/maxunpool_12_24.sv
// Max-unpooling: rebuilds a 2*ROWS x 2*COLS map from pooled values and their
// 2x2 argmax positions, one pooled row per cycle behind a start/end handshake.
module maxunpool_12_24 #(
  parameter int DATA_W = 4,
  parameter int ROWS   = 12,
  parameter int COLS   = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_flag,
  input  logic [ROWS*COLS*DATA_W-1:0]    in,
  input  logic [ROWS*COLS*2-1:0]         idx,
  output logic [4*ROWS*COLS*DATA_W-1:0]  out,
  output logic                           end_flag,
  output logic                           busy
);

  localparam int IN_W      = ROWS * COLS * DATA_W;
  localparam int IDX_W     = ROWS * COLS * 2;
  localparam int OUT_W     = 4 * ROWS * COLS * DATA_W;
  localparam int IN_ROW_W  = COLS * DATA_W;
  localparam int IDX_ROW_W = COLS * 2;
  localparam int PAIR_W    = 4 * COLS * DATA_W;
  localparam int ROW_CW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ROW_CW-1:0]   row_cnt;
  logic [IN_W-1:0]     in_q;
  logic [IDX_W-1:0]    idx_q;
  logic [OUT_W-1:0]    work;
  logic [PAIR_W-1:0]   pair_block;
  logic                last_row;

  assign last_row = (row_cnt == ROW_CW'(ROWS - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_flag) next_state = RUN;
      RUN:     if (last_row) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The current pooled row always sits at the top of the shifted latches; its
  // two output rows form one contiguous block, so each window is placed locally.
  always_comb begin
    pair_block = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          if (idx_q[IDX_W-1-2*c -: 2] == 2'(2*i + j)) begin
            pair_block[PAIR_W-1-(i*2*COLS + 2*c + j)*DATA_W -: DATA_W] =
              in_q[IN_W-1-c*DATA_W -: DATA_W];
          end
        end
      end
    end
  end

  // Row blocks shift into the working buffer from the bottom, so after the
  // last row the first block has reached the top, matching MSB-first order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt  <= '0;
      in_q     <= '0;
      idx_q    <= '0;
      work     <= '0;
      out      <= '0;
      end_flag <= 1'b0;
    end else begin
      end_flag <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_flag) begin
            in_q    <= in;
            idx_q   <= idx;
            row_cnt <= '0;
          end
        end
        RUN: begin
          work  <= {work[OUT_W-PAIR_W-1:0], pair_block};
          in_q  <= in_q << IN_ROW_W;
          idx_q <= idx_q << IDX_ROW_W;
          if (!last_row) row_cnt <= row_cnt + 1'b1;
        end
        DONE: out <= work;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxunpool_12_24.sv
// Directed bench for maxunpool_12_24: expected frames are queued at start and
// compared against out when end_flag arrives.
module tb_maxunpool_12_24;

  logic          clk;
  logic          reset;
  logic          start_flag;
  logic [575:0]  in_v;
  logic [287:0]  idx_v;
  logic [2303:0] out;
  logic          end_flag;
  logic          busy;

  logic [2303:0] exp_q[$];
  logic [2303:0] last_exp;
  int            cyc;
  int            start_cyc;
  int            checks;
  int            passes;
  int            fails;

  maxunpool_12_24 dut (
    .clk        (clk),
    .reset      (reset),
    .start_flag (start_flag),
    .in         (in_v),
    .idx        (idx_v),
    .out        (out),
    .end_flag   (end_flag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] pix(input logic [2303:0] v, input int y, input int x);
    return v[2303-(y*24+x)*4 -: 4];
  endfunction

  // Reference works output-pixel first: find the owning window and test its argmax.
  function automatic logic [2303:0] model(input logic [575:0] vi, input logic [287:0] vx);
    logic [2303:0] m;
    logic [1:0]    k;
    int            r;
    int            c;
    m = '0;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 24; x++) begin
        r = y / 2;
        c = x / 2;
        k = vx[287-(r*12+c)*2 -: 2];
        if (k == 2'((y % 2) * 2 + (x % 2)))
          m[2303-(y*24+x)*4 -: 4] = vi[575-(r*12+c)*4 -: 4];
      end
    end
    return m;
  endfunction

  task automatic set_pattern(input int mode);
    int val;
    int id;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        case (mode)
          0:       begin val = 15;                       id = 0; end
          1:       begin val = (r + c) % 16;             id = (r*12 + c) % 4; end
          2:       begin val = (r*3 + c*5 + 7) % 16;     id = (r + 2*c) % 4; end
          3:       begin val = int'($urandom_range(15)); id = int'($urandom_range(3)); end
          default: begin val = (r == 0 && c == 0) ? 9 : 0; id = 3; end
        endcase
        in_v[575-(r*12+c)*4 -: 4]  = 4'(val);
        idx_v[287-(r*12+c)*2 -: 2] = 2'(id);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs are scrambled right after the start edge; the frame must not notice.
  task automatic applyStimulus(input int mode);
    set_pattern(mode);
    exp_q.push_back(model(in_v, idx_v));
    start_flag = 1'b1;
    tick();
    start_cyc  = cyc;
    start_flag = 1'b0;
    in_v  = ~in_v;
    idx_v = ~idx_v;
  endtask

  task automatic waitEnd(input string tag);
    while (!end_flag && (cyc - start_cyc) < 20) tick();
    check_val({tag, "_latency"}, 32'(cyc - start_cyc), 32'd13);
  endtask

  task automatic checkOutput(input string tag);
    logic [2303:0] e;
    int            bad;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $error("[TB] FAIL %s_scoreboard: got empty queue, expected a pending frame", tag);
    end else begin
      e        = exp_q.pop_front();
      last_exp = e;
      bad      = -1;
      checks++;
      assert (out === e) passes++;
      else begin
        fails++;
        for (int p = 0; p < 576; p++)
          if (bad < 0 && out[2303-p*4 -: 4] !== e[2303-p*4 -: 4]) bad = p;
        $error("[TB] FAIL %s_out: pixel (%0d,%0d) got %h, expected %h", tag,
               bad / 24, bad % 24, out[2303-bad*4 -: 4], e[2303-bad*4 -: 4]);
      end
    end
    check_val({tag, "_end_flag"}, 32'(end_flag), 32'd1);
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    repeat (n) begin
      tick();
      if (end_flag !== 1'b0) pulses++;
    end
    check_val(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    fails      = 0;
    cyc        = 0;
    reset      = 1'b1;
    start_flag = 1'b0;
    in_v       = '0;
    idx_v      = '0;
    last_exp   = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_val("reset_out", 32'(out === '0), 32'd1);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_end_flag", 32'(end_flag), 32'd0);

    $display("[TB] test 1: all F, idx 0");
    applyStimulus(0);
    check_val("t1_busy_run", 32'(busy), 32'd1);
    waitEnd("t1");
    checkOutput("t1");
    check_val("t1_pix00", 32'(pix(out, 0, 0)), 32'hF);
    check_val("t1_pix01", 32'(pix(out, 0, 1)), 32'h0);
    check_val("t1_pix10", 32'(pix(out, 1, 0)), 32'h0);
    check_val("t1_pix11", 32'(pix(out, 1, 1)), 32'h0);
    check_val("t1_pix22", 32'(pix(out, 22, 22)), 32'hF);
    tick();
    check_val("t1_end_width", 32'(end_flag), 32'd0);

    $display("[TB] test 2: ramp values, cycling idx");
    applyStimulus(1);
    waitEnd("t2");
    checkOutput("t2");

    $display("[TB] test 3: start during busy is ignored");
    tick();
    applyStimulus(2);
    waitEnd("t3a");
    checkOutput("t3a");
    tick();
    applyStimulus(3);
    repeat (4) tick();
    set_pattern(1);
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    check_val("t3_out_hold", 32'(out === last_exp), 32'd1);
    waitEnd("t3b");
    checkOutput("t3b");
    check_quiet("t3_single_end", 20);

    $display("[TB] test 4: reset mid-run");
    applyStimulus(1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_val("t4_out_zero", 32'(out === '0), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd0);
    check_quiet("t4_no_end", 2);
    applyStimulus(2);
    waitEnd("t4");
    checkOutput("t4");

    $display("[TB] test 5: back-to-back frames");
    tick();
    applyStimulus(3);
    waitEnd("t5a");
    checkOutput("t5a");
    applyStimulus(1);
    waitEnd("t5b");
    checkOutput("t5b");

    $display("[TB] test 6: single value at idx 3");
    tick();
    applyStimulus(4);
    waitEnd("t6");
    checkOutput("t6");
    check_val("t6_pix11", 32'(pix(out, 1, 1)), 32'h9);
    check_val("t6_pix00", 32'(pix(out, 0, 0)), 32'h0);
    check_val("t6_pix01", 32'(pix(out, 0, 1)), 32'h0);
    check_val("t6_pix10", 32'(pix(out, 1, 0)), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
